obi_sbr_mem: RTL and testbench
==============================

# obi_sbr_mem

OBI subordinate (responder) that terminates the A/R channels driven by our OBI master. It serves read and write accesses to a small word-addressed register memory. Grant wait states are programmable, and a response buffer lets the master hold several transactions outstanding and apply `rready` backpressure. It sits on the subordinate side of the OBI link, as a bring-up and verification target and as a scratch register block.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: address width, 32 or 64.
- `DATA_WIDTH`, 32: data width, 32 or 64. `BE_W = DATA_WIDTH/8`; `OFS = $clog2(BE_W)`.
- `NUM_WORDS`, 16: memory depth in words, power of two, at least 2.
- `BASE_ADDR`, 0: byte address of word 0, aligned to `BE_W`.
- `GNT_WAIT`, 0: number of cycles `obi_req_i` must be high before `obi_gnt_o` is asserted.
- `RSP_DEPTH`, 2: response buffer depth, which is also the maximum number of outstanding transactions, at least 1.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`, in, 1: clock.
- `reset_ni`, in, 1: asynchronous active-low reset.
- `obi_req_i`, in, 1: A-channel request.
- `obi_gnt_o`, out, 1: A-channel grant.
- `obi_addr_i`, in, `ADDR_WIDTH`: byte address.
- `obi_we_i`, in, 1: 1 = write, 0 = read.
- `obi_be_i`, in, `BE_W`: byte enables.
- `obi_wdata_i`, in, `DATA_WIDTH`: write data.
- `obi_rvalid_o`, out, 1: R-channel valid.
- `obi_rready_i`, in, 1: R-channel ready.
- `obi_rdata_o`, out, `DATA_WIDTH`: read data; 0 for writes.
- `obi_err_o`, out, 1: decode error.

## Operation
- **Accept.** A transaction is accepted on a rising edge where `obi_req_i && obi_gnt_o`. At most one transaction is accepted per cycle.
- **Grant rule.** `obi_gnt_o = obi_req_i && (wait_cnt == GNT_WAIT) && (count < RSP_DEPTH)`.
  - Grant is combinational from `obi_req_i`.
  - Same-cycle pop does not bypass the full check; a full buffer blocks grant even when a pop occurs in that cycle.
- **Wait counter FSM.** `wait_cnt` is `max(1,$clog2(GNT_WAIT+1))` bits wide. States:
  - IDLE: `wait_cnt` = 0.
  - WAIT: while `obi_req_i` is high and `wait_cnt < GNT_WAIT`, increment `wait_cnt` each cycle.
  - READY: `wait_cnt == GNT_WAIT`; hold there while not granted.
  - Return to IDLE (`wait_cnt` = 0) on accept, or when `obi_req_i` drops.
  - With `GNT_WAIT = 0`, grant is asserted in the first cycle of the request.
- **Decode.**
  - `idx = (addr - BASE_ADDR) >> OFS`.
  - The access is valid iff `addr >= BASE_ADDR`, `idx < NUM_WORDS`, and `addr[OFS-1:0] == 0`.
  - Comparisons are done at `ADDR_WIDTH` width; the subtraction must not wrap.
- **Valid write.** At the accept edge, update every byte `k` of `mem[idx]` for which `obi_be_i[k]` is set. Push response {rdata = 0, err = 0}.
- **Valid read.** Read `mem[idx]` as it was before the accept edge, i.e. all prior writes are visible. Push {rdata = `mem[idx]`, err = 0}. `obi_be_i` is ignored for reads.
- **Invalid access.** No memory update. Push {rdata = 0, err = 1}.
- **Response buffer.**
  - In-order FIFO: push on accept, pop on `obi_rvalid_o && obi_rready_i`.
  - Push and pop in the same cycle leave `count` unchanged.
  - `obi_rvalid_o = (count != 0)`. `obi_rdata_o` and `obi_err_o` show the head entry, and show 0 when the buffer is empty.
- **R-channel stability.** While `obi_rvalid_o` is high and `obi_rready_i` is low, `obi_rdata_o` and `obi_err_o` are held stable.

## Timing
- **Reset values.** While `reset_ni` is low:
  - `obi_gnt_o` = 0, `obi_rvalid_o` = 0, `obi_rdata_o` = 0, `obi_err_o` = 0.
  - `mem` = 0, `count` = 0, `wait_cnt` = 0.
  - Queued responses are discarded.
- **Reset deassertion.** A request may be granted in the first cycle after reset deasserts, per `GNT_WAIT`.
- **Grant latency.** `obi_gnt_o` rises `GNT_WAIT` cycles after `obi_req_i` rises, provided the buffer is not full.
- **Response latency.** `obi_rvalid_o` is 1 starting in the cycle after the accept edge, at the earliest. There is no combinational path from A-channel inputs to R-channel outputs.
- **Back-to-back throughput.** With `GNT_WAIT = 0` and `obi_rready_i` held at 1, one transaction completes per cycle at full throughput.
- **Full buffer.** With `count == RSP_DEPTH`, `obi_gnt_o` is 0. It returns to 1 in the cycle after the pop edge.

## Structure
- Package `obi_sbr_pkg` holds:
  - `obi_rsp_t` struct {`rdata`, `err`}, parameterised via a `DATA_WIDTH` localparam default.
  - The wait FSM enum {IDLE, WAIT, READY}.
- Sub-module `obi_rsp_fifo`:
  - Parameters: `DEPTH`, type `T`.
  - Ports: `push`/`pop`, `full`/`empty`, head output.
  - Storage is pointer-based with wrap-around, clocked on `clk_i` with asynchronous `reset_ni`.
- The top level contains the wait FSM, the decode, and the byte-masked memory.

## Test plan
1. **Write then read.** Defaults. Write `0xDEADBEEF` to `0x8` with be=`1111`, then read `0x8`. Expect a grant in the request cycle, `rvalid` one cycle after each accept, and for the read rdata=`0xDEADBEEF`, err=0.
2. **Byte enables.** Write `0x0000AB00` with be=`0010` over `0xDEADBEEF` at `0x8`, then read `0x8`. Expect `0xDEADABEF`.
3. **Decode errors.** Read `0x40` (`NUM_WORDS*4`) and write `0x2` (misaligned). Expect err=1 and rdata=0 for both, with `mem` unchanged on readback.
4. **Backpressure.** Hold `rready`=0 and issue 3 back-to-back reads of `0x0`, `0x4`, `0x8` preloaded with 1, 2, 3. Expect grants for the first two only, `gnt`=0 while full, and the third granted the cycle after the first pop. Responses return 1, 2, 3 in order, and the data is held stable while stalled.
5. **Grant wait states.** With `GNT_WAIT=2`, assert `req` in cycle 0. Expect `gnt` first high in cycle 2. Drop `req` in cycle 1 and re-raise it; expect the count to restart.
6. **Reset mid-operation.** With 2 responses queued, assert `reset_ni`=0 asynchronously. Expect `rvalid`, `gnt`, `rdata` and `err` to go to 0 immediately, and reads of any written address to return 0 after reset.

Source files
------------

// File: rtl/obi_sbr_pkg.sv
// Shared types for the OBI subordinate memory: response record and grant-wait FSM states.
package obi_sbr_pkg;

   localparam int OBI_DATA_WIDTH = 32;

   // Default-width response; the top re-declares the same shape at its own DATA_WIDTH.
   typedef struct packed {
      logic [OBI_DATA_WIDTH-1:0] rdata;
      logic                      err;
   } obi_rsp_t;

   typedef enum logic [1:0] {IDLE, WAIT, READY} wait_state_e;

endpackage

// File: rtl/obi_rsp_fifo.sv
// In-order response buffer: circular storage with wrapping read/write pointers.
module obi_rsp_fifo #(
   parameter int  DEPTH = 2,
   parameter type T     = logic
) (
   input  logic clk_i,
   input  logic reset_ni,
   input  logic push,
   input  T     push_data,
   input  logic pop,
   output logic full,
   output logic empty,
   output T     head
);

   localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int            CW   = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CMAX = CW'(DEPTH);

   T              store [DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic          do_push, do_pop;

   assign full    = (count == CMAX);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Head reads as zero when nothing is queued so the R channel idles clean.
   always_comb begin
      head = '0;
      if (!empty) head = store[rptr];
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) store[i] <= '0;
      end else begin
         if (do_push) begin
            store[wptr] <= push_data;
            wptr        <= (wptr == LAST) ? '0 : wptr + 1'b1;
         end
         if (do_pop) rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/obi_sbr_mem.sv
// OBI subordinate serving a small word-addressed register memory with
// programmable grant wait states and a buffered, in-order R channel.
module obi_sbr_mem
   import obi_sbr_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    NUM_WORDS  = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    GNT_WAIT   = 0,
   parameter int                    RSP_DEPTH  = 2
) (
   input  logic                    clk_i,
   input  logic                    reset_ni,
   input  logic                    obi_req_i,
   output logic                    obi_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
   input  logic                    obi_we_i,
   input  logic [DATA_WIDTH/8-1:0] obi_be_i,
   input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
   output logic                    obi_rvalid_o,
   input  logic                    obi_rready_i,
   output logic [DATA_WIDTH-1:0]   obi_rdata_o,
   output logic                    obi_err_o
);

   localparam int                    BE_W = DATA_WIDTH / 8;
   localparam int                    OFS  = $clog2(BE_W);
   localparam int                    IW   = $clog2(NUM_WORDS);
   localparam int                    WCW  = (GNT_WAIT > 0) ? $clog2(GNT_WAIT + 1) : 1;
   localparam logic [WCW-1:0]        GW   = WCW'(GNT_WAIT);
   localparam logic [ADDR_WIDTH-1:0] NW   = ADDR_WIDTH'(NUM_WORDS);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] rdata;
      logic                  err;
   } rsp_t;

   wait_state_e                          state;
   logic [WCW-1:0]                       wait_cnt;
   logic                                 wait_done, accept, addr_ok;
   logic                                 fifo_full, fifo_empty;
   logic [ADDR_WIDTH-1:0]                word;
   logic [IW-1:0]                        idx;
   logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] mem;
   rsp_t                                 rsp_in, rsp_head;

   // READY covers the hold; the compare covers the first request cycle when GNT_WAIT is 0.
   assign wait_done = (state == READY) || (wait_cnt == GW);
   assign obi_gnt_o = reset_ni && obi_req_i && wait_done && !fifo_full;
   assign accept    = obi_req_i && obi_gnt_o;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else if (!obi_req_i || accept) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else if (wait_cnt == GW) begin
         state    <= READY;
      end else begin
         wait_cnt <= wait_cnt + 1'b1;
         state    <= (wait_cnt + 1'b1 == GW) ? READY : WAIT;
      end
   end

   // The base check guards the subtraction, so a wrapped offset never decodes as valid.
   assign word    = (obi_addr_i - BASE_ADDR) >> OFS;
   assign addr_ok = (obi_addr_i >= BASE_ADDR) && (word < NW) &&
                    (obi_addr_i[OFS-1:0] == '0);
   assign idx     = word[IW-1:0];

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         mem <= '0;
      end else if (accept && obi_we_i && addr_ok) begin
         for (int k = 0; k < BE_W; k++)
            if (obi_be_i[k]) mem[idx][k*8 +: 8] <= obi_wdata_i[k*8 +: 8];
      end
   end

   always_comb begin
      rsp_in     = '0;
      rsp_in.err = !addr_ok;
      if (addr_ok && !obi_we_i) rsp_in.rdata = mem[idx];
   end

   obi_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .T     (rsp_t)
   ) u_rsp_fifo (
      .clk_i     (clk_i),
      .reset_ni  (reset_ni),
      .push      (accept),
      .push_data (rsp_in),
      .pop       (obi_rready_i),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (rsp_head)
   );

   assign obi_rvalid_o = !fifo_empty;
   assign obi_rdata_o  = rsp_head.rdata;
   assign obi_err_o    = rsp_head.err;

endmodule

// File: tb/tb_obi_sbr_mem.sv
// Bench for obi_sbr_mem: directed scenarios plus random traffic against a queue/array model.
module tb_obi_sbr_mem;

   localparam int DEPTH = 2;

   logic        clk, reset_n;
   logic        req, gnt, we, rvalid, rready, err;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  be;
   logic        req2, gnt2, we2, rvalid2, rready2, err2;
   logic [31:0] addr2, wdata2, rdata2;
   logic [3:0]  be2;

   obi_sbr_mem dut (
      .clk_i(clk), .reset_ni(reset_n), .obi_req_i(req), .obi_gnt_o(gnt),
      .obi_addr_i(addr), .obi_we_i(we), .obi_be_i(be), .obi_wdata_i(wdata),
      .obi_rvalid_o(rvalid), .obi_rready_i(rready), .obi_rdata_o(rdata), .obi_err_o(err)
   );

   obi_sbr_mem #(.GNT_WAIT(2)) dut_w (
      .clk_i(clk), .reset_ni(reset_n), .obi_req_i(req2), .obi_gnt_o(gnt2),
      .obi_addr_i(addr2), .obi_we_i(we2), .obi_be_i(be2), .obi_wdata_i(wdata2),
      .obi_rvalid_o(rvalid2), .obi_rready_i(rready2), .obi_rdata_o(rdata2), .obi_err_o(err2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mmem [16];
   int          n_pass = 0, n_chk = 0;
   logic        s_gnt, s_rvalid, s_err;
   logic [31:0] s_rdata;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   task automatic model_accept(input bit w, input logic [31:0] a, input logic [3:0] b,
                               input logic [31:0] d);
      exp_t e;
      bit   ok;
      ok      = (a % 4 == 0) && (a / 4 < 16);
      e.rdata = '0;
      e.err   = !ok;
      if (ok && !w) e.rdata = mmem[a/4];
      if (ok && w)
         for (int k = 0; k < 4; k++) if (b[k]) mmem[a/4][k*8 +: 8] = d[k*8 +: 8];
      q.push_back(e);
   endtask

   task automatic clear_model();
      q.delete();
      for (int i = 0; i < 16; i++) mmem[i] = '0;
   endtask

   // One cycle on the default instance: drive, check against the model, then advance it.
   task automatic step(input bit r, input bit w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input bit rr);
      bit exp_g;
      @(negedge clk);
      req = r; we = w; addr = a; be = b; wdata = d; rready = rr;
      #1;
      s_gnt = gnt; s_rvalid = rvalid; s_rdata = rdata; s_err = err;
      exp_g = r && (q.size() < DEPTH);
      chk("gnt", gnt, exp_g);
      chk("rvalid", rvalid, q.size() != 0);
      if (q.size() != 0) begin
         chk("rdata", rdata, q[0].rdata);
         chk("err", err, q[0].err);
      end else begin
         chk("rdata_idle", rdata, 0);
         chk("err_idle", err, 0);
      end
      @(posedge clk);
      if (q.size() != 0 && rr) void'(q.pop_front());
      if (exp_g) model_accept(w, a, b, d);
   endtask

   task automatic tick_w(input bit r, input bit exp_g, input string tag);
      @(negedge clk);
      req2 = r;
      #1;
      chk(tag, gnt2, exp_g);
   endtask

   initial begin
      logic [31:0] a;
      clear_model();
      reset_n = 0; req = 1; we = 0; addr = 0; be = 0; wdata = 0; rready = 1;
      req2 = 0; we2 = 0; addr2 = 32'h4; be2 = 4'hf; wdata2 = 0; rready2 = 1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_err", err, 0);
      req = 0;
      reset_n = 1;

      // write then read
      step(1, 1, 32'h8, 4'hf, 32'hDEADBEEF, 1);
      chk("t1_wr_gnt", s_gnt, 1);
      step(1, 0, 32'h8, 4'hf, 0, 1);
      chk("t1_rd_gnt", s_gnt, 1);
      chk("t1_wr_rvalid", s_rvalid, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("t1_rdata", s_rdata, 32'hDEADBEEF);
      chk("t1_err", s_err, 0);

      // byte enables
      step(1, 1, 32'h8, 4'b0010, 32'h0000AB00, 1);
      step(1, 0, 32'h8, 4'hf, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("t2_rdata", s_rdata, 32'hDEADABEF);

      // decode errors: out of range read, misaligned write
      step(1, 0, 32'h40, 4'hf, 0, 1);
      step(1, 1, 32'h2, 4'hf, 32'hFFFFFFFF, 1);
      chk("t3_rd_err", s_err, 1);
      chk("t3_rd_rdata", s_rdata, 0);
      step(1, 0, 32'h0, 4'hf, 0, 1);
      chk("t3_wr_err", s_err, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("t3_readback", s_rdata, 0);
      chk("t3_readback_err", s_err, 0);

      // backpressure with a full buffer
      step(1, 1, 32'h0, 4'hf, 32'd1, 1);
      step(1, 1, 32'h4, 4'hf, 32'd2, 1);
      step(1, 1, 32'h8, 4'hf, 32'd3, 1);
      step(0, 0, 0, 0, 0, 1);
      step(1, 0, 32'h0, 4'hf, 0, 0);
      chk("t4_gnt_a", s_gnt, 1);
      step(1, 0, 32'h4, 4'hf, 0, 0);
      chk("t4_gnt_b", s_gnt, 1);
      step(1, 0, 32'h8, 4'hf, 0, 0);
      chk("t4_full_gnt", s_gnt, 0);
      chk("t4_hold0", s_rdata, 1);
      step(1, 0, 32'h8, 4'hf, 0, 0);
      chk("t4_hold1", s_rdata, 1);
      step(1, 0, 32'h8, 4'hf, 0, 1);
      chk("t4_pop_gnt", s_gnt, 0);
      step(1, 0, 32'h8, 4'hf, 0, 1);
      chk("t4_regrant", s_gnt, 1);
      chk("t4_second", s_rdata, 2);
      step(0, 0, 0, 0, 0, 1);
      chk("t4_third", s_rdata, 3);
      step(0, 0, 0, 0, 0, 1);

      // grant wait states on the GNT_WAIT=2 instance
      tick_w(1, 0, "t5_c0");
      tick_w(1, 0, "t5_c1");
      tick_w(1, 1, "t5_c2");
      tick_w(0, 0, "t5_idle");
      chk("t5_rvalid", rvalid2, 1);
      chk("t5_rdata", rdata2, 0);
      tick_w(1, 0, "t5_r0");
      tick_w(0, 0, "t5_drop");
      tick_w(1, 0, "t5_restart0");
      tick_w(1, 0, "t5_restart1");
      tick_w(1, 1, "t5_restart2");
      tick_w(0, 0, "t5_end");

      // asynchronous reset with responses queued
      step(1, 1, 32'h8, 4'hf, 32'h12345678, 1);
      step(0, 0, 0, 0, 0, 1);
      step(1, 0, 32'h8, 4'hf, 0, 0);
      step(1, 0, 32'hC, 4'hf, 0, 0);
      @(negedge clk);
      req = 1; addr = 32'h10; we = 0; rready = 0;
      #1;
      chk("t6_pre_rdata", rdata, 32'h12345678);
      #1;
      reset_n = 0;
      #1;
      chk("t6_rvalid", rvalid, 0);
      chk("t6_gnt", gnt, 0);
      chk("t6_rdata", rdata, 0);
      chk("t6_err", err, 0);
      @(negedge clk);
      req = 0;
      reset_n = 1;
      clear_model();
      step(1, 0, 32'h8, 4'hf, 0, 1);
      chk("t6_first_gnt", s_gnt, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("t6_readback", s_rdata, 0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         a = 32'($urandom_range(0, 19)) * 4;
         if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
         if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FFF0;
         step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
              4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 9) < 7);
      end
      repeat (3) step(0, 0, 0, 0, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
